// File: rtl/ngy_grid_video_out_if.sv
// Video output bundle for the Pocket scaler: pixel strobe, colour and sync flags.
interface ngy_grid_video_out_if;
  logic        vid_pix_ce;
  logic [23:0] vid_rgb;
  logic        vid_de;
  logic        vid_hs;
  logic        vid_vs;

  modport master (
    output vid_pix_ce,
    output vid_rgb,
    output vid_de,
    output vid_hs,
    output vid_vs
  );

  modport slave (
    input vid_pix_ce,
    input vid_rgb,
    input vid_de,
    input vid_hs,
    input vid_vs
  );
endinterface

// File: rtl/ngy_grid_video_out.sv
// Renders the snake core's one-bit grid as square cells on a small raster and
// produces Pocket video timing. The grid is captured once per frame on entry
// into vertical blank, so a visible frame never mixes two grid states.
module ngy_grid_video_out #(
  parameter int          GRID_ROWS  = 30,
  parameter int          GRID_COLS  = 40,
  parameter int          CELL_W     = 8,
  parameter int          CELL_H     = 8,
  parameter int          PIX_DIV    = 12,
  parameter int          H_ACTIVE   = 320,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 32,
  parameter int          H_BP       = 32,
  parameter int          V_ACTIVE   = 240,
  parameter int          V_FP       = 4,
  parameter int          V_SYNC     = 4,
  parameter int          V_BP       = 12,
  parameter int          GRID_LINES = 1,
  parameter logic [23:0] ON_COLOR   = 24'h00FF00,
  parameter logic [23:0] OFF_COLOR  = 24'h000000,
  parameter logic [23:0] LINE_COLOR = 24'h202020
) (
  input  logic                             clk_74a,
  input  logic                             reset,
  input  logic [0:GRID_ROWS*GRID_COLS-1]   grid_ram,
  ngy_grid_video_out_if.master             vid,
  output logic                             frame_start
);

  localparam int N       = GRID_ROWS * GRID_COLS;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter widths hold the totals themselves so sync end bounds never truncate.
  localparam int DW  = $clog2(PIX_DIV);
  localparam int HW  = $clog2(H_TOTAL + 1);
  localparam int VW  = $clog2(V_TOTAL + 1);
  localparam int SXW = $clog2(CELL_W);
  localparam int SYW = $clog2(CELL_H);
  localparam int CW  = $clog2(GRID_COLS);
  localparam int RW  = $clog2(GRID_ROWS);
  localparam int IW  = $clog2(N);

  localparam logic [DW-1:0]  DIV_LAST  = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_SNAP    = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]  VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SXW-1:0] SX_LAST   = SXW'(CELL_W - 1);
  localparam logic [SYW-1:0] SY_LAST   = SYW'(CELL_H - 1);
  localparam logic [CW-1:0]  COL_LAST  = CW'(GRID_COLS - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(GRID_ROWS - 1);
  localparam logic [IW-1:0]  ROW_STEP  = IW'(GRID_COLS);

  logic [DW-1:0]  div_cnt;
  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [SXW-1:0] sub_x;
  logic [SYW-1:0] sub_y;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [IW-1:0]  row_base;
  logic [IW-1:0]  cell_idx;
  logic [0:N-1]   snapshot;

  logic           pix_ce;
  logic           h_wrap;
  logic           v_wrap;
  logic           de_next;
  logic           hs_next;
  logic           vs_next;
  logic [23:0]    rgb_next;

  assign pix_ce      = (div_cnt == DIV_LAST);
  assign h_wrap      = (h_cnt == H_LAST);
  assign v_wrap      = (v_cnt == V_LAST);
  assign frame_start = pix_ce && h_wrap && (v_cnt == V_SNAP);
  assign cell_idx    = row_base + IW'(col);
  assign vid.vid_pix_ce = pix_ce;

  // Pixel clock divider: free-running count that strobes on its last value.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (pix_ce) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Raster position: h_cnt per pixel, v_cnt per line, both wrapping.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Cell tracking alongside the raster, so the grid index needs no multiplier.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      sub_x    <= '0;
      col      <= '0;
      sub_y    <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        sub_x <= '0;
        col   <= '0;
        if (v_wrap) begin
          sub_y    <= '0;
          row      <= '0;
          row_base <= '0;
        end else if (v_cnt < V_ACT) begin
          if (sub_y == SY_LAST) begin
            sub_y <= '0;
            if (row == ROW_LAST) begin
              row      <= '0;
              row_base <= '0;
            end else begin
              row      <= row + RW'(1);
              row_base <= row_base + ROW_STEP;
            end
          end else begin
            sub_y <= sub_y + SYW'(1);
          end
        end
      end else if (h_cnt < H_ACT) begin
        if (sub_x == SX_LAST) begin
          sub_x <= '0;
          col   <= (col == COL_LAST) ? '0 : col + CW'(1);
        end else begin
          sub_x <= sub_x + SXW'(1);
        end
      end
    end
  end

  // Grid capture at the start of vertical blank, the only time it may change.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      snapshot <= '0;
    end else if (frame_start) begin
      snapshot <= grid_ram;
    end
  end

  // Colour and timing flags for the pixel at the current raster position.
  always_comb begin
    de_next  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_next  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_next  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    rgb_next = 24'h000000;
    if (de_next) begin
      if ((GRID_LINES != 0) && ((sub_x == SX_LAST) || (sub_y == SY_LAST))) begin
        rgb_next = LINE_COLOR;
      end else if (snapshot[cell_idx]) begin
        rgb_next = ON_COLOR;
      end else begin
        rgb_next = OFF_COLOR;
      end
    end
  end

  // Output registers load on the strobe, one pixel period behind the counters.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      vid.vid_rgb <= '0;
      vid.vid_de  <= 1'b0;
      vid.vid_hs  <= 1'b0;
      vid.vid_vs  <= 1'b0;
    end else if (pix_ce) begin
      vid.vid_rgb <= rgb_next;
      vid.vid_de  <= de_next;
      vid.vid_hs  <= hs_next;
      vid.vid_vs  <= vs_next;
    end
  end

endmodule

// File: tb/tb_ngy_grid_video_out.sv
// Directed bench for the grid video renderer. One instance uses the full
// 320x240 timing for strobe and line checks; two reduced-raster instances
// (4x3 cells of 8x8, 44x30 total, divide by 2) cover frame-level behaviour
// with and without separator lines.
module tb_ngy_grid_video_out;

  localparam logic [31:0] ON_RGB   = 32'h0000FF00;
  localparam logic [31:0] OFF_RGB  = 32'h00000000;
  localparam logic [31:0] LINE_RGB = 32'h00202020;

  // Reduced raster: H_TOTAL 44, V_TOTAL 30, frame 1320 strobes, snapshot at strobe 23*44+43.
  localparam int S_HT    = 44;
  localparam int S_FRAME = 1320;
  localparam int S_SNAP  = 1055;

  logic        clk_74a = 1'b0;
  logic        reset   = 1'b1;
  logic [0:1199] grid_full  = '0;
  logic [0:11]   grid_small = '0;
  logic [0:11]   grid_nl    = '0;
  logic        fs_full;
  logic        fs_small;
  logic        fs_nl;

  int tests_run    = 0;
  int tests_failed = 0;
  int s_idx        = -1;
  int fs_count     = 0;
  int fs_last      = -1;

  ngy_grid_video_out_if vid_full ();
  ngy_grid_video_out_if vid_small ();
  ngy_grid_video_out_if vid_nl ();

  always #5 clk_74a = ~clk_74a;

  ngy_grid_video_out dut_full (
    .clk_74a     (clk_74a),
    .reset       (reset),
    .grid_ram    (grid_full),
    .vid         (vid_full),
    .frame_start (fs_full)
  );

  ngy_grid_video_out #(
    .GRID_ROWS(3), .GRID_COLS(4), .PIX_DIV(2),
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(4), .H_BP(4),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .GRID_LINES(1)
  ) dut_small (
    .clk_74a     (clk_74a),
    .reset       (reset),
    .grid_ram    (grid_small),
    .vid         (vid_small),
    .frame_start (fs_small)
  );

  ngy_grid_video_out #(
    .GRID_ROWS(3), .GRID_COLS(4), .PIX_DIV(2),
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(4), .H_BP(4),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .GRID_LINES(0)
  ) dut_nl (
    .clk_74a     (clk_74a),
    .reset       (reset),
    .grid_ram    (grid_nl),
    .vid         (vid_nl),
    .frame_start (fs_nl)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Holds reset high for the given number of cycles; the caller releases it.
  task automatic applyStimulus(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk_74a);
  endtask

  // Waits for the next full-timing strobe, then samples one cycle later.
  task automatic stepFull(output int waited);
    waited = 0;
    do begin
      @(negedge clk_74a);
      waited++;
    end while (!vid_full.vid_pix_ce && waited < 64);
    if (!vid_full.vid_pix_ce) begin
      checkOutput("full_ce_timeout", 32'(vid_full.vid_pix_ce), 32'd1);
      $fatal(1, "[TB] no pixel strobe from full-timing instance");
    end
    @(negedge clk_74a);
  endtask

  // Advances the reduced raster by one strobe, logging frame_start pulses.
  task automatic stepSmall();
    int waited = 0;
    do begin
      @(negedge clk_74a);
      waited++;
    end while (!vid_small.vid_pix_ce && waited < 16);
    if (!vid_small.vid_pix_ce) begin
      checkOutput("small_ce_timeout", 32'(vid_small.vid_pix_ce), 32'd1);
      $fatal(1, "[TB] no pixel strobe from reduced instance");
    end
    s_idx++;
    if (fs_small) begin
      fs_count++;
      fs_last = s_idx;
    end
    @(negedge clk_74a);
  endtask

  // After this returns, outputs show the pixel of strobe number target.
  task automatic gotoSmall(input int target);
    while (s_idx < target) stepSmall();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int de_count;
    int hs_count;
    int first_hs;

    // Reset holds every output low.
    applyStimulus(5);
    checkOutput("rst_ce",    32'(vid_full.vid_pix_ce), 32'd0);
    checkOutput("rst_rgb",   32'(vid_full.vid_rgb),    32'd0);
    checkOutput("rst_de",    32'(vid_full.vid_de),     32'd0);
    checkOutput("rst_hs",    32'(vid_full.vid_hs),     32'd0);
    checkOutput("rst_vs",    32'(vid_full.vid_vs),     32'd0);
    checkOutput("rst_fs",    32'(fs_full),             32'd0);
    checkOutput("rst_fs_nl", 32'(fs_nl),               32'd0);

    reset = 1'b0;
    @(negedge clk_74a);
    checkOutput("post_rst_de", 32'(vid_full.vid_de),     32'd0);
    checkOutput("post_rst_ce", 32'(vid_full.vid_pix_ce), 32'd0);

    // First strobe lands in the 12th cycle counting the release cycle as the 1st.
    stepFull(waited);
    checkOutput("first_ce_cycle", 32'(waited + 2), 32'd12);

    // One full line of the 320x240 timing, sampled once per strobe.
    de_count = 0;
    hs_count = 0;
    first_hs = -1;
    for (int s = 0; s <= 400; s++) begin
      if (s > 0) begin
        stepFull(waited);
        if (s == 1) checkOutput("ce_period", 32'(waited + 1), 32'd12);
      end
      if (s < 400) begin
        if (vid_full.vid_de) de_count++;
        if (vid_full.vid_hs) begin
          hs_count++;
          if (first_hs < 0) first_hs = s;
        end
      end
      if (s == 0) begin
        checkOutput("full_px0_de",  32'(vid_full.vid_de),  32'd1);
        checkOutput("full_px0_rgb", 32'(vid_full.vid_rgb), OFF_RGB);
      end
      if (s == 7)   checkOutput("full_px7_line", 32'(vid_full.vid_rgb), LINE_RGB);
      if (s == 320) begin
        checkOutput("full_px320_de",  32'(vid_full.vid_de),  32'd0);
        checkOutput("full_px320_rgb", 32'(vid_full.vid_rgb), 32'd0);
      end
      if (s == 400) checkOutput("full_line1_de", 32'(vid_full.vid_de), 32'd1);
    end
    checkOutput("line_de_count", 32'(de_count), 32'd320);
    checkOutput("line_hs_count", 32'(hs_count), 32'd32);
    checkOutput("line_hs_start", 32'(first_hs), 32'd336);

    // Reduced raster: cell 0 set on the normal bench, last cell on the no-line bench.
    grid_small[0] = 1'b1;
    grid_nl[11]   = 1'b1;
    applyStimulus(3);
    reset = 1'b0;
    s_idx = -1;
    fs_count = 0;
    fs_last = -1;

    // Frame 0 still shows the blank snapshot taken at reset.
    gotoSmall(0);
    checkOutput("f0_px00_de",  32'(vid_small.vid_de),  32'd1);
    checkOutput("f0_px00_rgb", 32'(vid_small.vid_rgb), OFF_RGB);
    gotoSmall(7);
    checkOutput("f0_px70_rgb", 32'(vid_small.vid_rgb), LINE_RGB);
    gotoSmall(S_SNAP);
    checkOutput("fs_first_count", 32'(fs_count), 32'd1);
    checkOutput("fs_first_idx",   32'(fs_last),  32'(S_SNAP));

    // Vertical sync spans lines 26 and 27 of the reduced raster.
    gotoSmall(25 * S_HT);
    checkOutput("vs_line25", 32'(vid_small.vid_vs), 32'd0);
    gotoSmall(26 * S_HT);
    checkOutput("vs_line26", 32'(vid_small.vid_vs), 32'd1);
    gotoSmall(27 * S_HT + 43);
    checkOutput("vs_line27_end", 32'(vid_small.vid_vs), 32'd1);
    gotoSmall(28 * S_HT);
    checkOutput("vs_line28", 32'(vid_small.vid_vs), 32'd0);

    // Frame 1 renders the captured grid.
    gotoSmall(S_FRAME);
    checkOutput("f1_px00_on", 32'(vid_small.vid_rgb), ON_RGB);
    gotoSmall(S_FRAME + 8);
    checkOutput("f1_px80_off", 32'(vid_small.vid_rgb), OFF_RGB);
    gotoSmall(S_FRAME + 3 * S_HT + 7);
    checkOutput("f1_px73_line", 32'(vid_small.vid_rgb), LINE_RGB);
    gotoSmall(S_FRAME + 6 * S_HT + 6);
    checkOutput("f1_px66_on", 32'(vid_small.vid_rgb), ON_RGB);
    gotoSmall(S_FRAME + 7 * S_HT + 3);
    checkOutput("f1_px37_line", 32'(vid_small.vid_rgb), LINE_RGB);
    gotoSmall(S_FRAME + 16 * S_HT + 24);
    checkOutput("nl_last_cell_tl", 32'(vid_nl.vid_rgb), ON_RGB);
    gotoSmall(S_FRAME + 23 * S_HT + 31);
    checkOutput("nl_last_pixel",    32'(vid_nl.vid_rgb),    ON_RGB);
    checkOutput("small_last_pixel", 32'(vid_small.vid_rgb), LINE_RGB);
    gotoSmall(S_FRAME + S_SNAP);
    checkOutput("fs_second_count", 32'(fs_count), 32'd2);
    checkOutput("fs_second_idx",   32'(fs_last),  32'(S_FRAME + S_SNAP));

    // Mid-frame grid change stays hidden until the next capture.
    gotoSmall(2 * S_FRAME + 10 * S_HT);
    grid_small[6] = 1'b1;
    gotoSmall(2 * S_FRAME + 12 * S_HT + 16);
    checkOutput("tear_same_frame", 32'(vid_small.vid_rgb), OFF_RGB);
    gotoSmall(3 * S_FRAME + 12 * S_HT + 16);
    checkOutput("tear_next_frame", 32'(vid_small.vid_rgb), ON_RGB);
    checkOutput("fs_third_count",  32'(fs_count), 32'd3);

    // Reset partway along a line abandons the frame and clears the snapshot.
    gotoSmall(3 * S_FRAME + 12 * S_HT + 20);
    applyStimulus(2);
    checkOutput("midrst_de",  32'(vid_small.vid_de),  32'd0);
    checkOutput("midrst_rgb", 32'(vid_small.vid_rgb), 32'd0);
    reset = 1'b0;
    s_idx = -1;
    fs_count = 0;
    gotoSmall(0);
    checkOutput("restart_px00_de",  32'(vid_small.vid_de),  32'd1);
    checkOutput("restart_px00_rgb", 32'(vid_small.vid_rgb), OFF_RGB);
    gotoSmall(12 * S_HT + 16);
    checkOutput("restart_cell6_off", 32'(vid_small.vid_rgb), OFF_RGB);
    gotoSmall(16 * S_HT + 24);
    checkOutput("restart_nl_off", 32'(vid_nl.vid_rgb), OFF_RGB);
    checkOutput("restart_no_fs",  32'(fs_count),       32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ngy_grid_video_out.md
Name: ngy_grid_video_out

Overview:
- Downstream consumer of the snake core's 30x40 one-bit grid RAM vector.
- Renders the grid as 8x8-pixel cells into a 320x240 active raster and generates the timing for the Pocket video output (RGB, DE, HS, VS) on a divided pixel enable.
- Latches the grid once per frame at the start of vertical blank, so a frame never shows a partly updated grid (no tearing).

Parameters:
- GRID_ROWS, 30, grid rows.
- GRID_COLS, 40, grid columns; cell count N = GRID_ROWS*GRID_COLS = 1200.
- CELL_W, 8, cell width in pixels; GRID_COLS*CELL_W must equal H_ACTIVE.
- CELL_H, 8, cell height in pixels; GRID_ROWS*CELL_H must equal V_ACTIVE.
- PIX_DIV, 12, clk_74a cycles per pixel (>=2).
- H_ACTIVE/H_FP/H_SYNC/H_BP, 320/16/32/32, horizontal timing in pixels; H_TOTAL = 400.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 240/4/4/12, vertical timing in lines; V_TOTAL = 260.
- GRID_LINES, 1, 1 = draw the cell separator colour on the last column and last row of each cell.
- ON_COLOR, 24'h00FF00, colour of a set cell.
- OFF_COLOR, 24'h000000, colour of a clear cell.
- LINE_COLOR, 24'h202020, separator colour.

Ports:
- clk_74a  in  1  system clock (74.25 MHz).
- reset  in  1  synchronous, active-high reset.
- grid_ram  in  [0:N-1]  grid from the snake core; bit index = row*GRID_COLS + col; bit 0 is the top-left cell.
- vid_pix_ce  out  1  one-clk_74a-wide pixel strobe, once every PIX_DIV cycles.
- vid_rgb  out  24  pixel colour {R,G,B}.
- vid_de  out  1  active-video flag.
- vid_hs  out  1  horizontal sync, active-high.
- vid_vs  out  1  vertical sync, active-high.
- frame_start  out  1  one-clock pulse marking the grid snapshot.

Behaviour:
Reset:
- While reset is high at a clk_74a edge, all state clears: divider counter, h_cnt, v_cnt, cell and sub-cell counters, and the snapshot register all go to 0.
- All outputs read 0 from the following cycle.
- Reset mid-line or mid-frame abandons the current frame; the raster restarts at (0,0) with a blank snapshot.

Pixel strobe:
- A divider counts 0..PIX_DIV-1.
- vid_pix_ce = 1 for exactly the cycle in which the counter equals PIX_DIV-1.
- The first strobe comes PIX_DIV cycles after reset is released.

Counters (advance only when vid_pix_ce = 1):
- h_cnt counts 0..H_TOTAL-1 and wraps.
- On an h_cnt wrap, v_cnt counts 0..V_TOTAL-1 and wraps.
- Cell position is tracked incrementally with no multiply or divide: sub_x 0..CELL_W-1, col, sub_y 0..CELL_H-1, row.
- A row base register is reset to 0 and advanced by GRID_COLS per cell row. Cell index = row base + col.

Output timing:
- Outputs are registered and update on the strobe cycle, from the counter values held just before that edge.
- Latency is one pixel-enable period from counter state to outputs.
- vid_de = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- vid_hs = 1 for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vid_vs = 1 for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; it changes only on an h_cnt wrap.
- vid_rgb is 0 whenever vid_de = 0.

Colour when active:
- If GRID_LINES = 1 and (sub_x = CELL_W-1 or sub_y = CELL_H-1): LINE_COLOR.
- Otherwise, if snapshot[index] = 1: ON_COLOR.
- Otherwise: OFF_COLOR.

Snapshot:
- Loaded from grid_ram in a single cycle on the strobe where h_cnt = H_TOTAL-1 and v_cnt = V_ACTIVE-1 (entry into vertical blank).
- frame_start pulses high for that same cycle.
- Changes to grid_ram at any other time have no visible effect until the next snapshot.

Test Plan:
1. Reset behaviour: hold reset 5 cycles, then release. All outputs are 0 during and immediately after reset; the first vid_pix_ce arrives 12 cycles after release and repeats every 12 cycles.
2. Horizontal timing: count strobes over one line. vid_de is high for 320 strobes; vid_hs is high for 32 strobes starting 336 strobes after the first DE of the line; the line lasts 400 strobes.
3. Vertical timing: vid_vs is high for 4 lines starting at line 244; frame_start pulses once per 104000 strobes.
4. Cell rendering: set only grid_ram[0] and wait for the snapshot. Pixels (0..6, 0..6) = 00FF00; pixels x=7 or y=7 = 202020; pixel (8,0) = 000000.
5. Last cell: set only grid_ram[1199]. Pixels (312..318, 232..238) = 00FF00. With GRID_LINES=0, pixel (319,239) = 00FF00.
6. Tearing and mid-frame reset: toggle grid_ram[620] at v_cnt = 100. No change appears until after the next frame_start. Asserting reset at h_cnt = 150 restarts the raster at (0,0) with all-OFF cells.
